muldiv_unit: RTL and testbench

- Iterative RV32M multiply/divide unit in the execute stage, in parallel with the ALU.
- Takes the same SrcA/SrcB operands the ALU uses.
- Its Result is muxed with ALUResult at the EX/MEM boundary.
- Holds the pipeline via busy while an operation runs, and supports flush on a branch mispredict.

---
 rtl/muldiv_unit_pkg.sv | 35 +++
 rtl/muldiv_unit_if.sv | 25 ++
 rtl/muldiv_unit_div_step.sv | 21 ++
 rtl/muldiv_unit.sv | 142 ++++++++++++++
 tb/tb_muldiv_unit.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/muldiv_unit_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [2:0] {
    MUL    = 3'b000,
    MULH   = 3'b001,
    MULHSU = 3'b010,
    MULHU  = 3'b011,
    DIV    = 3'b100,
    DIVU   = 3'b101,
    REM    = 3'b110,
    REMU   = 3'b111
  } muldiv_op;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } muldiv_state;

  localparam int unsigned MULDIV_ITER = 32;

  function automatic logic op_is_div(input muldiv_op op);
    return op[2];
  endfunction

  function automatic logic op_a_signed(input muldiv_op op);
    return op inside {MUL, MULH, MULHSU, DIV, REM};
  endfunction

  function automatic logic op_b_signed(input muldiv_op op);
    return op inside {MUL, MULH, DIV, REM};
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Execute-stage request/response bundle between the pipeline and muldiv_unit.
interface muldiv_unit_if
  import muldiv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  start;
  muldiv_op              MulDivOp;
  logic [DATA_WIDTH-1:0] SrcA;
  logic [DATA_WIDTH-1:0] SrcB;
  logic                  flush;
  logic                  busy;
  logic                  done;
  logic [DATA_WIDTH-1:0] Result;

  modport master (
    output start, MulDivOp, SrcA, SrcB, flush,
    input  busy, done, Result
  );

  modport slave (
    input  start, MulDivOp, SrcA, SrcB, flush,
    output busy, done, Result
  );
endinterface

// File: rtl/muldiv_unit_div_step.sv
// One combinational restoring-division step: shift in the next dividend bit, trial-subtract.
module div_step #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] rem,
  input  logic [W-1:0] quot,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] rem_next,
  output logic [W-1:0] quot_next
);
  logic [W:0] shifted;
  logic [W:0] diff;

  // rem < divisor always holds, so a set diff[W] means the trial subtraction went negative.
  always_comb begin
    shifted   = {rem, quot[W-1]};
    diff      = shifted - {1'b0, divisor};
    rem_next  = diff[W] ? shifted[W-1:0] : diff[W-1:0];
    quot_next = {quot[W-2:0], ~diff[W]};
  end
endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit (radix-2, DATA_WIDTH steps per op).
// Define MULDIV_FAST_MUL_EN for a single-cycle combinational multiplier.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = MULDIV_ITER
) (
  input logic           clk,
  input logic           rst,
  muldiv_unit_if.slave  bus
);
  localparam int unsigned W  = DATA_WIDTH;
  localparam int unsigned CW = $clog2(W);

  muldiv_state    state_q, state_d;
  muldiv_op       op_q;
  logic           sa_q, sb_q;
  logic [W-1:0]   opnd_q;
  logic [W-1:0]   result_q;
  logic [2*W-1:0] acc_q;
  logic [CW-1:0]  cnt_q;

  logic           a_neg, b_neg, div_zero, div_ovf, fast, accept, last;
  logic [W-1:0]   mag_a, mag_b;
  logic [W:0]     mul_sum;
  logic [2*W-1:0] mul_next, prod_fix;
  logic [W-1:0]   rem_next, quot_next, quo_fix, rem_fix, fin;

  always_comb begin
    a_neg    = op_a_signed(bus.MulDivOp) & bus.SrcA[W-1];
    b_neg    = op_b_signed(bus.MulDivOp) & bus.SrcB[W-1];
    mag_a    = a_neg ? -bus.SrcA : bus.SrcA;
    mag_b    = b_neg ? -bus.SrcB : bus.SrcB;
    div_zero = op_is_div(bus.MulDivOp) && (bus.SrcB == '0);
    div_ovf  = op_is_div(bus.MulDivOp) && op_b_signed(bus.MulDivOp) &&
               (bus.SrcA == {1'b1, {(W-1){1'b0}}}) && (bus.SrcB == '1);
`ifdef MULDIV_FAST_MUL_EN
    fast     = ~op_is_div(bus.MulDivOp);
`else
    fast     = 1'b0;
`endif
    accept   = (state_q == IDLE) && bus.start && !bus.flush;
    last     = (cnt_q == CW'(W-1));
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*W-1:0] fast_prod;
  always_comb fast_prod = {{W{1'b0}}, mag_a} * {{W{1'b0}}, mag_b};
`endif

  // Multiply: multiplier sits in the low half and is consumed LSB-first as the product shifts in.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next = {mul_sum, acc_q[W-1:1]};
  end

  div_step #(.W(W)) u_div_step (
    .rem       (acc_q[2*W-1:W]),
    .quot      (acc_q[W-1:0]),
    .divisor   (opnd_q),
    .rem_next  (rem_next),
    .quot_next (quot_next)
  );

  // Special cases preload acc with the final value and clear the sign flags, so fix-up is a no-op.
  always_comb begin
    prod_fix = (sa_q ^ sb_q) ? -acc_q : acc_q;
    quo_fix  = (sa_q ^ sb_q) ? -acc_q[W-1:0] : acc_q[W-1:0];
    rem_fix  = sa_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];
    case (op_q)
      MUL:                  fin = prod_fix[W-1:0];
      MULH, MULHSU, MULHU:  fin = prod_fix[2*W-1:W];
      DIV, DIVU:            fin = quo_fix;
      default:              fin = rem_fix;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = (div_zero || div_ovf || fast) ? DONE : CALC;
      CALC:    if (bus.flush) state_d = IDLE;
               else if (last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= MUL;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      opnd_q   <= '0;
      result_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (accept) begin
            op_q  <= bus.MulDivOp;
            cnt_q <= '0;
            if (div_zero) begin
              sa_q  <= 1'b0;
              sb_q  <= 1'b0;
              acc_q <= {bus.SrcA, {W{1'b1}}};
            end else if (div_ovf) begin
              sa_q  <= 1'b0;
              sb_q  <= 1'b0;
              acc_q <= {{W{1'b0}}, bus.SrcA};
            end else begin
              sa_q   <= a_neg;
              sb_q   <= b_neg;
              opnd_q <= op_is_div(bus.MulDivOp) ? mag_b : mag_a;
`ifdef MULDIV_FAST_MUL_EN
              if (fast) acc_q <= fast_prod;
              else
`endif
              acc_q  <= {{W{1'b0}}, op_is_div(bus.MulDivOp) ? mag_a : mag_b};
            end
          end
        end
        CALC: begin
          acc_q <= op_is_div(op_q) ? {rem_next, quot_next} : mul_next;
          cnt_q <= cnt_q + 1'b1;
        end
        DONE:    if (!bus.flush) result_q <= fin;
        default: ;
      endcase
    end
  end

  // Result is presented during the done cycle and committed on leaving DONE, so a flush there leaves it untouched.
  always_comb begin
    bus.busy   = (state_q == CALC);
    bus.done   = (state_q == DONE) && !bus.flush;
    bus.Result = bus.done ? fin : result_q;
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed plan cases plus randomized ops against a 64-bit arithmetic model.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  muldiv_unit_if #(.DATA_WIDTH(32)) bus ();

  muldiv_unit #(.DATA_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input muldiv_op op, input logic [31:0] a, input logic [31:0] b);
    longint      sa = longint'($signed(a));
    longint      sb = longint'($signed(b));
    longint      ubl = longint'({32'b0, b});
    logic [63:0] ua = {32'b0, a};
    logic [63:0] ub = {32'b0, b};
    logic [63:0] p;
    int          ia = $signed(a);
    int          ib = $signed(b);
    logic        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      MUL:    begin p = sa * sb;  return p[31:0];  end
      MULH:   begin p = sa * sb;  return p[63:32]; end
      MULHSU: begin p = sa * ubl; return p[63:32]; end
      MULHU:  begin p = ua * ub;  return p[63:32]; end
      DIV:    return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(ia / ib);
      REM:    return (b == 0) ? a : ovf ? 32'h0 : 32'(ia % ib);
      DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_lat(input muldiv_op op, input logic [31:0] a, input logic [31:0] b);
    if (op[2] && b == 0) return 1;
    if ((op == DIV || op == REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef MULDIV_FAST_MUL_EN
    if (!op[2]) return 1;
`endif
    return 33;
  endfunction

  task automatic do_op(input muldiv_op op, input logic [31:0] a, input logic [31:0] b, input logic ghost,
                       output logic [31:0] res, output int lat, output int bcnt, output logic got);
    bus.start = 1'b1; bus.MulDivOp = op; bus.SrcA = a; bus.SrcB = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.SrcA = $urandom; bus.SrcB = $urandom; bus.MulDivOp = muldiv_op'($urandom_range(0, 7));
    lat = 1; bcnt = 0; got = 1'b0; res = 'x;
    while (lat <= 100) begin
      if (bus.done) begin got = 1'b1; res = bus.Result; break; end
      if (bus.busy) bcnt++;
      bus.start = ghost && (lat == 5);
      @(posedge clk); #1;
      bus.start = 1'b0;
      lat++;
    end
  endtask

  task automatic run_check(input muldiv_op op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp, input logic ghost);
    logic [31:0] res;
    int          lat, bcnt;
    logic        got;
    string       t;
    t = $sformatf("%s %h,%h", op.name(), a, b);
    do_op(op, a, b, ghost, res, lat, bcnt, got);
    check({t, " done_seen"}, 32'(got), 32'd1);
    check({t, " result"}, res, exp);
    check({t, " latency"}, 32'(lat), 32'(exp_lat(op, a, b)));
    check({t, " busy_cycles"}, 32'(bcnt), 32'(exp_lat(op, a, b) - 1));
    @(posedge clk); #1;
    check({t, " done_pulse_end"}, 32'(bus.done), 32'd0);
    check({t, " result_hold"}, bus.Result, exp);
  endtask

  initial begin
    logic [31:0] a, b, prev;
    muldiv_op    op;
    logic        seen;

    rst = 1'b1;
    bus.start = 1'b0; bus.flush = 1'b0; bus.MulDivOp = MUL; bus.SrcA = '0; bus.SrcB = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);
    check("reset result", bus.Result, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed cases from the test plan
    run_check(MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
    run_check(MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
    run_check(MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 1'b0);
    run_check(MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_check(DIV,    32'hFFFF_FFEC,  32'd6,         32'hFFFF_FFFD, 1'b0);
    run_check(REM,    32'hFFFF_FFEC,  32'd6,         32'hFFFF_FFFE, 1'b0);
    run_check(DIVU,   32'd100,        32'd7,         32'd14,        1'b0);
    run_check(REMU,   32'd100,        32'd7,         32'd2,         1'b0);
    run_check(DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF, 1'b0);
    run_check(REM,    32'd5,          32'd0,         32'd5,         1'b0);
    run_check(DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
    run_check(REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'h0,         1'b0);

    // A second start while busy must be ignored
    run_check(MUL,    32'd1234,       32'd5678,      32'd7006652,   1'b1);
    run_check(DIVU,   32'd1000,       32'd9,         32'd111,       1'b1);

    // Randomized operations against the arithmetic model, with occasional corner operands
    for (int i = 0; i < 24; i++) begin
      op = muldiv_op'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = '0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = $urandom_range(1, 15);
        default: ;
      endcase
      run_check(op, a, b, model(op, a, b), 1'b0);
    end

    // Flush mid-CALC: back to IDLE, no done, Result unchanged
    prev = bus.Result;
    bus.start = 1'b1; bus.MulDivOp = DIV; bus.SrcA = 32'd100; bus.SrcB = 32'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    check("flush pre busy", 32'(bus.busy), 32'd1);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    check("flush busy", 32'(bus.busy), 32'd0);
    check("flush result", bus.Result, prev);
    seen = 1'b0;
    repeat (40) begin
      if (bus.done || bus.busy) seen = 1'b1;
      @(posedge clk); #1;
    end
    check("flush no done", 32'(seen), 32'd0);
    check("flush result held", bus.Result, prev);
    run_check(DIVU, 32'd9, 32'd3, 32'd3, 1'b0);

    // flush and start together in IDLE: nothing accepted
    prev = bus.Result;
    bus.start = 1'b1; bus.flush = 1'b1; bus.MulDivOp = DIVU; bus.SrcA = 32'd5; bus.SrcB = 32'd0;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.flush = 1'b0;
    check("flush+start done", 32'(bus.done), 32'd0);
    check("flush+start busy", 32'(bus.busy), 32'd0);
    check("flush+start result", bus.Result, prev);

    // Asynchronous reset in the middle of CALC
    bus.start = 1'b1; bus.MulDivOp = REMU; bus.SrcA = 32'd77; bus.SrcB = 32'd5;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (8) begin @(posedge clk); #1; end
    check("prereset busy", 32'(bus.busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async reset busy", 32'(bus.busy), 32'd0);
    check("async reset done", 32'(bus.done), 32'd0);
    check("async reset result", bus.Result, 32'd0);
    #3 rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done) seen = 1'b1;
    end
    check("reset no done", 32'(seen), 32'd0);
    run_check(REMU, 32'd77, 32'd5, 32'd2, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
